// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// mem_arbiter_pkg: size encodings, FSM states and address/size helpers shared by mem_arbiter. Rev 1.0
package mem_arbiter_pkg;

   localparam logic [1:0] SIZE_BYTE   = 2'd0;
   localparam logic [1:0] SIZE_HALF   = 2'd1;
   localparam logic [1:0] SIZE_WORD   = 2'd2;
   localparam logic [2:0] FETCH_BYTES = 3'd4;

   typedef enum logic [1:0] {
      ST_IDLE    = 2'd0,
      ST_READ    = 2'd1,
      ST_WRITE   = 2'd2,
      ST_IO_WAIT = 2'd3
   } arb_state_t;

   // UART/IO space is any address whose bits [17:16] are both set
   function automatic logic is_io_addr(input logic [31:0] addr);
      return (addr & 32'h0003_0000) == 32'h0003_0000;
   endfunction

   function automatic logic [2:0] size_bytes(input logic [1:0] size);
      case (size)
         SIZE_BYTE: return 3'd1;
         SIZE_HALF: return 3'd2;
         SIZE_WORD: return 3'd4;
         default:   return 3'd4;
      endcase
   endfunction

   function automatic logic [31:0] extend_load(input logic [31:0] raw, input logic [1:0] size,
                                               input logic sgn);
      case (size)
         SIZE_BYTE: return {{24{sgn & raw[7]}}, raw[7:0]};
         SIZE_HALF: return {{16{sgn & raw[15]}}, raw[15:0]};
         default:   return raw;
      endcase
   endfunction

endpackage
`default_nettype wire

// File: rtl/mem_arb_pick.sv
`default_nettype none
// mem_arb_pick: combinational grant selector; fixed load/store priority, or round-robin when
// MEM_ARB_ROUND_ROBIN_EN is defined. Rev 1.0
module mem_arb_pick (
   input  logic if_req,
   input  logic ls_req,
`ifdef MEM_ARB_ROUND_ROBIN_EN
   input  logic last_ls,
`endif
   output logic grant_if,
   output logic grant_ls
);

   always_comb begin
      grant_if = 1'b0;
      grant_ls = 1'b0;
      if (if_req && ls_req) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
         if (last_ls) grant_if = 1'b1;
         else         grant_ls = 1'b1;
`else
         grant_ls = 1'b1;
`endif
      end else begin
         grant_if = if_req;
         grant_ls = ls_req;
      end
   end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// mem_arbiter: arbitrates fetch and load/store onto a byte-wide RAM/IO bus.
// Optional MEM_ARB_ROUND_ROBIN_EN selects round-robin grants. Rev 1.0
module mem_arbiter
   import mem_arbiter_pkg::*;
(
   input  logic        clk_in,
   input  logic        rst_n_in,
   input  logic        rdy_in,
   input  logic        clear,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_done,
   output logic [31:0] if_data,
   input  logic        ls_req,
   input  logic        ls_we,
   input  logic [1:0]  ls_size,
   input  logic        ls_signed,
   input  logic [31:0] ls_addr,
   input  logic [31:0] ls_wdata,
   output logic        ls_done,
   output logic [31:0] ls_rdata,
   input  logic [7:0]  mem_din,
   output logic [7:0]  mem_dout,
   output logic [31:0] mem_a,
   output logic        mem_wr,
   input  logic        io_buffer_full
);

   arb_state_t  state, state_nxt;
   logic [2:0]  cnt, nbytes;
   logic [31:0] addr_q, wdata_q, asm_q, asm_nxt;
   logic [1:0]  size_q, rd_idx;
   logic        signed_q, sel_ls;
   logic        stalled;
   logic [7:0]  din_hold, byte_in;
   logic        grant_if, grant_ls, grant_en;
`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic        last_ls;
`endif

   mem_arb_pick u_pick (
      .if_req   (if_req),
      .ls_req   (ls_req),
`ifdef MEM_ARB_ROUND_ROBIN_EN
      .last_ls  (last_ls),
`endif
      .grant_if (grant_if),
      .grant_ls (grant_ls)
   );

   always_comb begin
      state_nxt = state;
      grant_en  = 1'b0;
      mem_a     = '0;
      mem_dout  = '0;
      mem_wr    = 1'b0;
      // The RAM keeps running while rdy_in is low, so the byte due at the first stalled
      // edge is parked in din_hold and consumed on resume.
      byte_in   = stalled ? din_hold : mem_din;
      rd_idx    = cnt[1:0] - 2'd1;
      asm_nxt   = asm_q;
      asm_nxt[{rd_idx, 3'b000} +: 8] = byte_in;
      case (state)
         ST_IDLE: begin
            // No grant while a done pulse is out: the finishing requester still holds req.
            if (!clear && !if_done && !ls_done && (grant_if || grant_ls)) begin
               grant_en = 1'b1;
               if (grant_ls && ls_we)
                  state_nxt = (is_io_addr(ls_addr) && io_buffer_full) ? ST_IO_WAIT : ST_WRITE;
               else
                  state_nxt = ST_READ;
            end
         end
         ST_READ: begin
            if (cnt < nbytes) mem_a = addr_q + {29'd0, cnt};
            if (clear || cnt == nbytes) state_nxt = ST_IDLE;
         end
         ST_WRITE: begin
            mem_a    = addr_q + {29'd0, cnt};
            mem_dout = wdata_q[{cnt[1:0], 3'b000} +: 8];
            mem_wr   = rdy_in;
            if (cnt == nbytes - 3'd1) state_nxt = ST_IDLE;
         end
         ST_IO_WAIT: begin
            if (!io_buffer_full) state_nxt = ST_WRITE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk_in or negedge rst_n_in) begin
      if (!rst_n_in) begin
         state    <= ST_IDLE;
         cnt      <= '0;
         nbytes   <= '0;
         addr_q   <= '0;
         wdata_q  <= '0;
         size_q   <= SIZE_BYTE;
         signed_q <= 1'b0;
         sel_ls   <= 1'b0;
         asm_q    <= '0;
         stalled  <= 1'b0;
         din_hold <= '0;
         if_done  <= 1'b0;
         ls_done  <= 1'b0;
         if_data  <= '0;
         ls_rdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_ls  <= 1'b0;
`endif
      end else if (rdy_in) begin
         state   <= state_nxt;
         stalled <= 1'b0;
         if_done <= 1'b0;
         ls_done <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (grant_en) begin
                  sel_ls   <= grant_ls;
                  addr_q   <= grant_ls ? ls_addr : if_addr;
                  wdata_q  <= ls_wdata;
                  size_q   <= grant_ls ? ls_size : SIZE_WORD;
                  signed_q <= grant_ls & ls_signed;
                  nbytes   <= grant_ls ? size_bytes(ls_size) : FETCH_BYTES;
                  cnt      <= '0;
                  asm_q    <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_ls  <= grant_ls;
`endif
               end
            end
            ST_READ: begin
               if (!clear) begin
                  cnt <= cnt + 3'd1;
                  if (cnt != 3'd0) asm_q <= asm_nxt;
                  if (cnt == nbytes) begin
                     if (sel_ls) begin
                        ls_done  <= 1'b1;
                        ls_rdata <= extend_load(asm_nxt, size_q, signed_q);
                     end else begin
                        if_done  <= 1'b1;
                        if_data  <= asm_nxt;
                     end
                  end
               end
            end
            ST_WRITE: begin
               cnt <= cnt + 3'd1;
               if (cnt == nbytes - 3'd1) ls_done <= 1'b1;
            end
            default: cnt <= '0;
         endcase
      end else if (!stalled) begin
         stalled  <= 1'b1;
         din_hold <= mem_din;
      end
   end

endmodule
`default_nettype wire
